// File: rtl/instruction_memory_responder.sv
// Responder side of the memory read request/ready/data handshake, backed by an
// instruction BRAM with a host write port, sticky out-of-range flag and read counter.
module instruction_memory_responder #(
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int DEPTH             = 2048,
    parameter int READ_LATENCY      = 1,
    parameter int COUNT_WIDTH       = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MEMORY_ADDR_WIDTH-1:0] memory_addr,
    input  logic                         memory_valid,
    output logic                         memory_ready,
    output logic [MEMORY_WIDTH-1:0]      memory_data,
    input  logic                         wr_valid,
    input  logic [MEMORY_ADDR_WIDTH-1:0] wr_addr,
    input  logic [MEMORY_WIDTH-1:0]      wr_data,
    output logic                         wr_ready,
    output logic                         oob_error,
    output logic [COUNT_WIDTH-1:0]       read_count
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [MEMORY_ADDR_WIDTH:0] DEPTH_L = (MEMORY_ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [1:0] WAIT_INIT = 2'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [MEMORY_WIDTH-1:0] mem [DEPTH];

    state_t                         state_q, state_d;
    logic [1:0]                     wait_cnt_q, wait_cnt_d;
    logic [MEMORY_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                           ready_q, ready_d;
    logic [MEMORY_WIDTH-1:0]        data_q, data_d;
    logic                           oob_q, oob_d;
    logic [COUNT_WIDTH-1:0]         count_q, count_d;

    logic                           mem_we;
    logic                           go_resp;
    logic [MEMORY_ADDR_WIDTH-1:0]   rd_addr;
    logic                           rd_oob;
    logic                           wr_oob;
    logic [MEMORY_WIDTH-1:0]        rd_word;

    // With single-cycle latency the word is fetched straight from the request address.
    assign rd_addr = (state_q == IDLE) ? memory_addr : addr_q;
    assign rd_oob  = {1'b0, rd_addr} >= DEPTH_L;
    assign wr_oob  = {1'b0, wr_addr} >= DEPTH_L;
    assign rd_word = mem[rd_addr[IDX_W-1:0]];

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        ready_d    = 1'b0;
        data_d     = data_q;
        oob_d      = oob_q;
        count_d    = count_q;
        mem_we     = 1'b0;
        wr_ready   = 1'b0;
        go_resp    = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_valid) begin
                    wr_ready = 1'b1;
                    if (wr_oob) oob_d = 1'b1;
                    else        mem_we = 1'b1;
                end else if (memory_valid) begin
                    addr_d = memory_addr;
                    if (rd_oob) oob_d = 1'b1;
                    if (READ_LATENCY == 1) begin
                        go_resp = 1'b1;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == 2'd0) go_resp = 1'b1;
                else                    wait_cnt_d = wait_cnt_q - 2'd1;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Data and count are registered on entry to RESP so they line up with the ready pulse.
        if (go_resp) begin
            state_d = RESP;
            ready_d = 1'b1;
            data_d  = rd_oob ? '0 : rd_word;
            if (count_q != {COUNT_WIDTH{1'b1}}) count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= 2'd0;
            addr_q     <= '0;
            ready_q    <= 1'b0;
            data_q     <= '0;
            oob_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            ready_q    <= ready_d;
            data_q     <= data_d;
            oob_q      <= oob_d;
            count_q    <= count_d;
        end
    end

    // Program contents survive reset; only the write itself is suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end

    assign memory_ready = ready_q;
    assign memory_data  = data_q;
    assign oob_error    = oob_q;
    assign read_count   = count_q;
endmodule

// File: tb/tb_instruction_memory_responder.sv
// Self-checking bench: three responder configurations share one directed stimulus
// stream; each has its own behavioural model, checked every cycle plus literal pins.
module tb_instruction_memory_responder;
    localparam int W  = 16;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          memory_valid = 1'b0;
    logic [AW-1:0] memory_addr = '0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;

    logic          act_ready [3];
    logic [W-1:0]  act_data  [3];
    logic          act_wrr   [3];
    logic          act_oob   [3];
    logic [31:0]   cnt0;
    logic [3:0]    cnt1;
    logic [3:0]    cnt2;

    int compared   = 0;
    int mismatched = 0;
    bit check_en   = 0;

    always #5 clk = ~clk;

    // Instance 0: full depth, latency 1, wide counter.
    instruction_memory_responder #(.MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW), .DEPTH(2048),
        .READ_LATENCY(1), .COUNT_WIDTH(32)) u_dut0 (
        .clk(clk), .rst(rst), .memory_addr(memory_addr), .memory_valid(memory_valid),
        .memory_ready(act_ready[0]), .memory_data(act_data[0]), .wr_valid(wr_valid),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(act_wrr[0]),
        .oob_error(act_oob[0]), .read_count(cnt0));

    // Instance 1: half depth, latency 3, 4-bit counter.
    instruction_memory_responder #(.MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW), .DEPTH(1024),
        .READ_LATENCY(3), .COUNT_WIDTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .memory_addr(memory_addr), .memory_valid(memory_valid),
        .memory_ready(act_ready[1]), .memory_data(act_data[1]), .wr_valid(wr_valid),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(act_wrr[1]),
        .oob_error(act_oob[1]), .read_count(cnt1));

    // Instance 2: half depth, latency 2, 4-bit counter.
    instruction_memory_responder #(.MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW), .DEPTH(1024),
        .READ_LATENCY(2), .COUNT_WIDTH(4)) u_dut2 (
        .clk(clk), .rst(rst), .memory_addr(memory_addr), .memory_valid(memory_valid),
        .memory_ready(act_ready[2]), .memory_data(act_data[2]), .wr_valid(wr_valid),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(act_wrr[2]),
        .oob_error(act_oob[2]), .read_count(cnt2));

    // Behavioural model: a read accepted in cycle t answers in cycle t+LAT, and the
    // responder ignores new requests until that answer has been given.
    for (genvar g = 0; g < 3; g++) begin : model
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 2;
        localparam int DEP = (g == 0) ? 2048 : 1024;
        localparam logic [31:0] CMAX = (g == 0) ? 32'hFFFF_FFFF : 32'd15;

        logic [W-1:0] mem_m [2048];
        bit           known [2048];
        int           t = 0;
        int           resp_cycle = -1;
        logic [W-1:0] resp_data = '0;
        bit           resp_known = 1'b1;
        bit           idle_now = 1'b1;
        logic         exp_ready = 1'b0;
        logic [W-1:0] exp_data = '0;
        bit           exp_known = 1'b1;
        logic         exp_oob = 1'b0;
        logic [31:0]  exp_cnt = '0;

        always @(posedge clk) begin
            bit idle;
            idle = (t > resp_cycle);
            if (rst) begin
                resp_cycle = t;
                exp_ready  = 1'b0;
                exp_data   = '0;
                exp_known  = 1'b1;
                exp_oob    = 1'b0;
                exp_cnt    = '0;
            end else begin
                if (idle && wr_valid) begin
                    if (int'(wr_addr) >= DEP) exp_oob = 1'b1;
                    else begin
                        mem_m[wr_addr] = wr_data;
                        known[wr_addr] = 1'b1;
                    end
                end else if (idle && memory_valid) begin
                    resp_cycle = t + LAT;
                    if (int'(memory_addr) >= DEP) begin
                        exp_oob    = 1'b1;
                        resp_data  = '0;
                        resp_known = 1'b1;
                    end else begin
                        resp_data  = mem_m[memory_addr];
                        resp_known = known[memory_addr];
                    end
                end
                exp_ready = (t + 1 == resp_cycle);
                if (exp_ready) begin
                    exp_data  = resp_data;
                    exp_known = resp_known;
                    if (exp_cnt != CMAX) exp_cnt = exp_cnt + 1;
                end
            end
            t = t + 1;
            idle_now = (t > resp_cycle);
        end
    end

    task automatic checkOutput(input string name, input int inst, input logic [31:0] act,
                               input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s inst%0d: got %h, want %h (t=%0t)", name, inst, act, exp, $time);
        end
    endtask

    task automatic checkInstance(input int i, input logic rdy, input logic [W-1:0] dat,
                                 input logic wrr, input logic oob, input logic [31:0] cnt,
                                 input logic e_rdy, input logic [W-1:0] e_dat, input bit e_known,
                                 input logic e_wrr, input logic e_oob, input logic [31:0] e_cnt);
        checkOutput("ready", i, {31'b0, rdy}, {31'b0, e_rdy});
        if (e_known) checkOutput("data", i, {16'b0, dat}, {16'b0, e_dat});
        checkOutput("wr_ready", i, {31'b0, wrr}, {31'b0, e_wrr});
        checkOutput("oob_error", i, {31'b0, oob}, {31'b0, e_oob});
        checkOutput("read_count", i, cnt, e_cnt);
    endtask

    // Every cycle after the first reset edge, all three instances are held to their models.
    always @(negedge clk) begin
        if (check_en) begin
            checkInstance(0, act_ready[0], act_data[0], act_wrr[0], act_oob[0], cnt0,
                model[0].exp_ready, model[0].exp_data, model[0].exp_known,
                wr_valid && model[0].idle_now, model[0].exp_oob, model[0].exp_cnt);
            checkInstance(1, act_ready[1], act_data[1], act_wrr[1], act_oob[1], {28'b0, cnt1},
                model[1].exp_ready, model[1].exp_data, model[1].exp_known,
                wr_valid && model[1].idle_now, model[1].exp_oob, model[1].exp_cnt);
            checkInstance(2, act_ready[2], act_data[2], act_wrr[2], act_oob[2], {28'b0, cnt2},
                model[2].exp_ready, model[2].exp_data, model[2].exp_known,
                wr_valid && model[2].idle_now, model[2].exp_oob, model[2].exp_cnt);
        end
    end

    task automatic applyStimulus(input bit r, input bit wv, input int wa, input int wd,
                                 input bit mv, input int ma);
        rst          = r;
        wr_valid     = wv;
        wr_addr      = AW'(wa);
        wr_data      = W'(wd);
        memory_valid = mv;
        memory_addr  = AW'(ma);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick(n);
    endtask

    // Directed scenario sequence with literal pins at the interesting cycles.
    initial begin
        logic [W-1:0] vals [4];
        logic [12:0]  trace;
        vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        trace = '0;

        applyStimulus(1, 0, 0, 0, 0, 0);
        tick(1);
        check_en = 1;
        tick(1);
        @(negedge clk);
        checkOutput("reset_ready", 0, {31'b0, act_ready[0]}, 32'd0);
        checkOutput("reset_data", 1, {16'b0, act_data[1]}, 32'd0);
        checkOutput("reset_count", 0, cnt0, 32'd0);
        idle(1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, i, int'(vals[i]), 0, 0);
            @(negedge clk);
            checkOutput("load_wr_ready", 0, {31'b0, act_wrr[0]}, 32'd1);
            tick(1);
        end
        applyStimulus(0, 1, 76, 16'h7676, 0, 0);
        tick(1);
        idle(1);

        applyStimulus(0, 0, 0, 0, 1, 2);
        tick(1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("read2_ready", 0, {31'b0, act_ready[0]}, 32'd1);
        checkOutput("read2_data", 0, {16'b0, act_data[0]}, 32'h3333);
        checkOutput("read2_count", 0, cnt0, 32'd1);
        idle(6);

        for (int k = 0; k < 13; k++) begin
            applyStimulus(0, 0, 0, 0, k < 12, 1);
            @(negedge clk);
            trace[k] = act_ready[1];
            if (act_ready[1]) checkOutput("hold_data", 1, {16'b0, act_data[1]}, 32'h2222);
            tick(1);
        end
        checkOutput("hold_ready_trace", 1, {19'b0, trace}, 32'h0888);
        idle(6);

        applyStimulus(0, 1, 5, 16'hABCD, 1, 5);
        @(negedge clk);
        checkOutput("simul_wr_ready", 0, {31'b0, act_wrr[0]}, 32'd1);
        tick(1);
        applyStimulus(0, 0, 0, 0, 1, 5);
        tick(1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("simul_ready", 0, {31'b0, act_ready[0]}, 32'd1);
        checkOutput("simul_data", 0, {16'b0, act_data[0]}, 32'hABCD);
        idle(6);

        applyStimulus(0, 0, 0, 0, 1, 2047);
        @(negedge clk);
        checkOutput("oob_before", 1, {31'b0, act_oob[1]}, 32'd0);
        tick(1);
        idle(2);
        @(negedge clk);
        checkOutput("oob_read_ready", 1, {31'b0, act_ready[1]}, 32'd1);
        checkOutput("oob_read_data", 1, {16'b0, act_data[1]}, 32'd0);
        checkOutput("oob_read_flag", 1, {31'b0, act_oob[1]}, 32'd1);
        checkOutput("oob_inrange_flag", 0, {31'b0, act_oob[0]}, 32'd0);
        idle(6);

        applyStimulus(0, 1, 1100, 16'hDEAD, 0, 0);
        @(negedge clk);
        checkOutput("oob_wr_ready", 1, {31'b0, act_wrr[1]}, 32'd1);
        tick(1);
        applyStimulus(0, 0, 0, 0, 1, 76);
        tick(1);
        idle(2);
        @(negedge clk);
        checkOutput("no_alias_data", 1, {16'b0, act_data[1]}, 32'h7676);
        checkOutput("oob_sticky", 1, {31'b0, act_oob[1]}, 32'd1);
        idle(6);

        applyStimulus(1, 0, 0, 0, 0, 0);
        tick(1);
        @(negedge clk);
        checkOutput("rst_clears_oob", 1, {31'b0, act_oob[1]}, 32'd0);
        checkOutput("rst_clears_count", 1, {28'b0, cnt1}, 32'd0);
        idle(2);

        applyStimulus(0, 0, 0, 0, 1, 3);
        tick(1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick(1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("midrst_ready", 2, {31'b0, act_ready[2]}, 32'd0);
        checkOutput("midrst_data", 2, {16'b0, act_data[2]}, 32'd0);
        checkOutput("midrst_count", 2, {28'b0, cnt2}, 32'd0);
        tick(1);
        @(negedge clk);
        checkOutput("midrst_ready_l3", 1, {31'b0, act_ready[1]}, 32'd0);
        idle(4);

        applyStimulus(0, 0, 0, 0, 1, 3);
        tick(1);
        idle(1);
        @(negedge clk);
        checkOutput("after_rst_ready", 2, {31'b0, act_ready[2]}, 32'd1);
        checkOutput("after_rst_data", 2, {16'b0, act_data[2]}, 32'h4444);
        checkOutput("after_rst_count", 2, {28'b0, cnt2}, 32'd1);
        idle(6);

        for (int n = 0; n < 17; n++) begin
            applyStimulus(0, 0, 0, 0, 1, n % 4);
            tick(1);
            idle(4);
        end
        idle(2);
        @(negedge clk);
        checkOutput("sat_count", 1, {28'b0, cnt1}, 32'd15);
        checkOutput("sat_count", 2, {28'b0, cnt2}, 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
